// File: rtl/dm_bytelane_if.sv
// Request/response bus between the EX/MEM stage and the byte-lane data memory.
interface dm_bytelane_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] pc;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, pc,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, pc,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dm_bytelane.sv
// Data memory with byte/half/word access, sign/zero-extended loads, registered
// response and a reset-triggered scrub that zeroes one word per cycle.
module dm_bytelane #(
  parameter int          ADDR_BITS  = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          LOG_WRITES = 1
) (
  input  logic           clk,
  input  logic           reset,
  dm_bytelane_if.slave   bus
);

  localparam int          DEPTH     = 2 ** (ADDR_BITS - 2);
  localparam int          IDX_W     = ADDR_BITS - 2;
  localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH);

  typedef enum logic {S_SCRUB, S_IDLE} state_t;

  state_t            state;
  logic [IDX_W-1:0]  clr_idx;
  logic [31:0]       mem [DEPTH];
  logic              ready_q;
  logic              busy_q;
  logic              vld_p1;
  logic              err_p1;
  logic [31:0]       rdata_p1;

  logic [31:0]       off;
  logic [IDX_W-1:0]  widx;
  logic [1:0]        lane;
  logic              accept;
  logic              bad;
  logic              store_we;
  logic [31:0]       old_word;
  logic [31:0]       merged;

  function automatic logic [31:0] lane_mask(input logic [1:0] size, input logic [1:0] ln);
    case (size)
      2'b00:   lane_mask = 32'h0000_00FF << {ln, 3'b000};
      2'b01:   lane_mask = 32'h0000_FFFF << {ln, 3'b000};
      default: lane_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] size, input logic [1:0] ln);
    logic [31:0] rep;
    logic [31:0] m;
    case (size)
      2'b00:   rep = {4{wd[7:0]}};
      2'b01:   rep = {2{wd[15:0]}};
      default: rep = wd;
    endcase
    m = lane_mask(size, ln);
    store_merge = (old & ~m) | (rep & m);
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] ln, input logic uns);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    sh = word >> {ln, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (size)
      2'b00:   ext = uns ? signed'({24'd0, sh[7:0]})  : 32'(b);
      2'b01:   ext = uns ? signed'({16'd0, sh[15:0]}) : 32'(h);
      default: ext = signed'(word);
    endcase
    load_extend = ext;
  endfunction

  always_comb begin
    off      = bus.req_addr - BASE_ADDR;
    widx     = off[ADDR_BITS-1:2];
    lane     = off[1:0];
    accept   = bus.req_valid & ready_q;
    bad      = (bus.req_size == 2'b11) ||
               (bus.req_size == 2'b01 && lane[0]) ||
               (bus.req_size == 2'b10 && lane != 2'b00) ||
               (off >= MEM_BYTES);
    store_we = accept & bus.req_we & ~bad & ~reset;
    old_word = mem[widx];
    merged   = store_merge(old_word, bus.req_wdata, bus.req_size, lane);
  end

  // Stage p1: control FSM and registered response
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_SCRUB;
      clr_idx  <= '0;
      busy_q   <= 1'b1;
      ready_q  <= 1'b0;
      vld_p1   <= 1'b0;
      err_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1 <= accept;
      case (state)
        S_SCRUB: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == IDX_W'(DEPTH - 1)) begin
            state   <= S_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        S_IDLE: begin
          if (accept) begin
            err_p1   <= bad;
            rdata_p1 <= (bad || bus.req_we) ? 32'd0
                        : load_extend(old_word, bus.req_size, lane, bus.req_unsigned);
          end
        end
        default: state <= S_SCRUB;
      endcase
    end
  end

  // Scrub owns the write port until IDLE; a restarted scrub begins again at index 0
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == S_SCRUB)
        mem[clr_idx] <= '0;
      else if (store_we)
        mem[widx] <= merged;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (LOG_WRITES != 0 && store_we)
      $write("@%h: *%h <= %h\n", bus.pc, {bus.req_addr[31:2], 2'b00}, merged);
  end
`endif

  assign bus.req_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = vld_p1;
  assign bus.rsp_err   = err_p1;
  assign bus.rsp_rdata = rdata_p1;

endmodule
